// File: rtl/dot_prod_pkg.sv
// Shared widths and FSM encoding for the dot-product accelerator host driver.
package dot_prod_pkg;

    localparam int ELEM_W      = 27;
    localparam int RES_W       = 64;
    localparam int ADDR_W      = 10;
    localparam int LEN_DEFAULT = 1000;

    typedef enum logic [2:0] {
        LOAD,
        WLAST,
        START,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/dot_prod_driver.sv
// Host-side initiator: streams LEN element pairs into the accelerator arrays,
// starts it, waits for completion (or timeout) and hands back the result.
//
// state | meaning
// LOAD  | accept pairs, write them into the accelerator arrays
// WLAST | final array write in flight
// START | accelerator start pulse with zero initial values
// RUN   | wait for acc_w_enable or timeout
// DONE  | result held until the consumer takes it
module dot_prod_driver
    import dot_prod_pkg::*;
#(
    parameter int LEN     = LEN_DEFAULT,
    parameter int ADDR_W  = dot_prod_pkg::ADDR_W,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                r_enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ELEM_W-1:0]   in_a,
    input  logic [ELEM_W-1:0]   in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_result,
    output logic                out_timeout,
    output logic                busy,
    output logic                acc_r_enable,
    output logic                acc_controlArr,
    output logic [ADDR_W-1:0]   acc_init_i,
    output logic [RES_W-1:0]    acc_init_acc,
    output logic                acc_we_a,
    output logic                acc_we_b,
    output logic [ADDR_W-1:0]   acc_addr_a,
    output logic [ADDR_W-1:0]   acc_addr_b,
    output logic [ELEM_W-1:0]   acc_wdata_a,
    output logic [ELEM_W-1:0]   acc_wdata_b,
    input  logic                acc_w_enable,
    input  logic [RES_W-1:0]    acc_result
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic                to_q, to_d;
    logic                out_valid_q;
    logic                busy_q;
    logic                r_en_q;
    logic                ctrl_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ELEM_W-1:0]   wdata_a_q, wdata_b_q;
    logic                accept;

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        to_d    = to_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    // idx stops at LEN-1 so it never wraps past the array
                    if (idx_q == ADDR_W'(LEN - 1)) state_d = WLAST;
                    else                           idx_d   = idx_q + ADDR_W'(1);
                end
            end
            WLAST: state_d = START;
            START: begin
                idx_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // completion takes priority over the final timeout count
                if (acc_w_enable) begin
                    res_d   = acc_result;
                    to_d    = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_enable) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            to_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            r_en_q      <= 1'b0;
            ctrl_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_a_q   <= '0;
            wdata_b_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            to_q        <= to_d;
            // outputs are registered from the next state so they line up with it
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != LOAD);
            r_en_q      <= (state_d == START);
            ctrl_q      <= (state_d == LOAD) || (state_d == WLAST);
            we_q        <= accept;
            if (accept) begin
                addr_q    <= idx_q;
                wdata_a_q <= in_a;
                wdata_b_q <= in_b;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = res_q;
    assign out_timeout    = to_q;
    assign busy           = busy_q;
    assign acc_r_enable   = r_en_q;
    assign acc_controlArr = ctrl_q;
    assign acc_init_i     = '0;
    assign acc_init_acc   = '0;
    assign acc_we_a       = we_q;
    assign acc_we_b       = we_q;
    assign acc_addr_a     = addr_q;
    assign acc_addr_b     = addr_q;
    assign acc_wdata_a    = wdata_a_q;
    assign acc_wdata_b    = wdata_b_q;

endmodule

// File: tb/tb_dot_prod_driver.sv
// Bench for dot_prod_driver: behavioural accelerator plus a second instance
// with a dead accelerator for the timeout path.
module tb_dot_prod_driver;
    import dot_prod_pkg::*;

    localparam int LEN = 1000;
    localparam int T_LEN = 4;
    localparam int T_TIMEOUT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                r_enable = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [ELEM_W-1:0]   in_a = '0, in_b = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [RES_W-1:0]    out_result;
    logic                out_timeout;
    logic                busy;
    logic                acc_r_enable, acc_controlArr;
    logic [ADDR_W-1:0]   acc_init_i;
    logic [RES_W-1:0]    acc_init_acc;
    logic                acc_we_a, acc_we_b;
    logic [ADDR_W-1:0]   acc_addr_a, acc_addr_b;
    logic [ELEM_W-1:0]   acc_wdata_a, acc_wdata_b;
    logic                acc_w_enable;
    logic [RES_W-1:0]    acc_result;

    dot_prod_driver #(.LEN(LEN), .ADDR_W(ADDR_W), .TIMEOUT(4096)) dut (
        .clk(clk), .r_enable(r_enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_timeout(out_timeout), .busy(busy),
        .acc_r_enable(acc_r_enable), .acc_controlArr(acc_controlArr),
        .acc_init_i(acc_init_i), .acc_init_acc(acc_init_acc),
        .acc_we_a(acc_we_a), .acc_we_b(acc_we_b),
        .acc_addr_a(acc_addr_a), .acc_addr_b(acc_addr_b),
        .acc_wdata_a(acc_wdata_a), .acc_wdata_b(acc_wdata_b),
        .acc_w_enable(acc_w_enable), .acc_result(acc_result)
    );

    logic                t_in_valid = 1'b0;
    logic                t_in_ready;
    logic [ELEM_W-1:0]   t_in_a = '0, t_in_b = '0;
    logic                t_out_valid;
    logic                t_out_ready = 1'b0;
    logic [RES_W-1:0]    t_out_result;
    logic                t_out_timeout, t_busy;
    logic                t_acc_r_enable, t_acc_controlArr;
    logic [ADDR_W-1:0]   t_acc_init_i;
    logic [RES_W-1:0]    t_acc_init_acc;
    logic                t_acc_we_a, t_acc_we_b;
    logic [ADDR_W-1:0]   t_acc_addr_a, t_acc_addr_b;
    logic [ELEM_W-1:0]   t_acc_wdata_a, t_acc_wdata_b;
    logic                t_acc_w_enable = 1'b0;
    logic [RES_W-1:0]    t_acc_result = '0;

    dot_prod_driver #(.LEN(T_LEN), .ADDR_W(ADDR_W), .TIMEOUT(T_TIMEOUT)) dut_to (
        .clk(clk), .r_enable(r_enable),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(t_in_a), .in_b(t_in_b),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_result(t_out_result),
        .out_timeout(t_out_timeout), .busy(t_busy),
        .acc_r_enable(t_acc_r_enable), .acc_controlArr(t_acc_controlArr),
        .acc_init_i(t_acc_init_i), .acc_init_acc(t_acc_init_acc),
        .acc_we_a(t_acc_we_a), .acc_we_b(t_acc_we_b),
        .acc_addr_a(t_acc_addr_a), .acc_addr_b(t_acc_addr_b),
        .acc_wdata_a(t_acc_wdata_a), .acc_wdata_b(t_acc_wdata_b),
        .acc_w_enable(t_acc_w_enable), .acc_result(t_acc_result)
    );

    // Behavioural accelerator: one MAC per cycle over its arrays, then a random tail delay.
    logic signed [ELEM_W-1:0] mem_a [0:1023];
    logic signed [ELEM_W-1:0] mem_b [0:1023];
    logic signed [RES_W-1:0]  acc_sum = '0;
    logic                     acc_run = 1'b0;
    logic                     acc_done = 1'b0;
    int                       acc_k = 0;
    int                       acc_delay = 0;

    always @(posedge clk) begin
        if (acc_we_a) mem_a[acc_addr_a] <= acc_wdata_a;
        if (acc_we_b) mem_b[acc_addr_b] <= acc_wdata_b;
        if (acc_r_enable) begin
            acc_run   <= 1'b1;
            acc_k     <= 0;
            acc_sum   <= $signed(acc_init_acc);
            acc_done  <= 1'b0;
            acc_delay <= int'($urandom_range(0, 15));
        end else if (acc_run) begin
            if (acc_k < LEN) begin
                acc_sum <= acc_sum + longint'(mem_a[acc_k]) * longint'(mem_b[acc_k]);
                acc_k   <= acc_k + 1;
            end else if (acc_delay != 0) begin
                acc_delay <= acc_delay - 1;
            end else begin
                acc_done <= 1'b1;
                acc_run  <= 1'b0;
            end
        end
    end
    assign acc_w_enable = acc_done;
    assign acc_result   = acc_sum;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int hs_cnt = 0, we_cnt = 0, last_acc_cyc = 0, start_cyc = 0, t_start_cyc = 0;
    logic first_pending = 1'b0;
    logic [ADDR_W-1:0] first_addr = '1;

    always @(negedge clk) begin
        if (in_valid && in_ready) begin
            hs_cnt       <= hs_cnt + 1;
            last_acc_cyc <= cyc;
        end
        if (acc_we_a) begin
            we_cnt <= we_cnt + 1;
            if (first_pending) begin
                first_addr    <= acc_addr_a;
                first_pending <= 1'b0;
            end
        end
        if (r_enable) first_pending <= 1'b1;
        if (acc_r_enable) start_cyc <= cyc;
        if (t_acc_r_enable) t_start_cyc <= cyc;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int qa[$];
    int qb[$];

    function automatic longint model_dot();
        longint s = 0;
        foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        r_enable = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        r_enable = 1'b0;
    endtask

    task automatic drive_pairs(input bit gaps, input int stop_after);
        int i = 0;
        while (i < stop_after) begin
            @(negedge clk);
            in_valid = !(gaps && ($urandom_range(0, 3) == 0));
            in_a = ELEM_W'(qa[i]);
            in_b = ELEM_W'(qb[i]);
            if (in_valid && in_ready) i++;
        end
    endtask

    task automatic run_job(input bit gaps, input int hold);
        int hs0, we0, n;
        longint exp;
        hs0 = hs_cnt;
        we0 = we_cnt;
        exp = model_dot();
        drive_pairs(gaps, LEN);
        // keep valid asserted across the LOAD->WLAST boundary
        repeat (2) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = ELEM_W'(5);
            in_b = ELEM_W'(7);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pairs_accepted", 64'(hs_cnt - hs0), 64'(LEN));
        check_eq("writes_issued", 64'(we_cnt - we0), 64'(LEN));
        check_eq("start_latency", 64'(start_cyc - last_acc_cyc), 64'd2);
        n = 0;
        while (!out_valid && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_reached", 64'(out_valid), 64'd1);
        check_eq("result", out_result, exp);
        check_eq("timeout_flag", 64'(out_timeout), 64'd0);
        check_eq("busy_done", 64'(busy), 64'd1);
        repeat (hold) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_result", out_result, exp);
            check_eq("hold_timeout", 64'(out_timeout), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("valid_cleared", 64'(out_valid), 64'd0);
        check_eq("back_to_load", 64'(in_ready), 64'd1);
    endtask

    task automatic fill_const(input int a, input int b);
        qa.delete();
        qb.delete();
        for (int i = 0; i < LEN; i++) begin
            qa.push_back(a);
            qb.push_back(b);
        end
    endtask

    initial begin
        logic signed [ELEM_W-1:0] ra, rb;
        int n, v;

        do_reset();
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ctrl_arr", 64'(acc_controlArr), 64'd1);
        check_eq("rst_acc_r_en", 64'(acc_r_enable), 64'd0);
        check_eq("rst_we", 64'(acc_we_a), 64'd0);
        check_eq("rst_result", out_result, 64'd0);
        check_eq("rst_timeout", 64'(out_timeout), 64'd0);

        fill_const(1, 1);
        run_job(1'b0, 0);

        qa.delete();
        qb.delete();
        for (int i = 0; i < LEN; i++) begin
            qa.push_back(i);
            qb.push_back(1);
        end
        check_eq("model_ramp", 64'(model_dot()), 64'd499500);
        run_job(1'b1, 0);

        fill_const(-67108864, 67108863);
        run_job(1'b1, 0);

        fill_const(1, 1);
        run_job(1'b0, 10);
        fill_const(2, 3);
        run_job(1'b1, 0);

        qa.delete();
        qb.delete();
        for (int i = 0; i < LEN; i++) begin
            ra = ELEM_W'($urandom);
            rb = ELEM_W'($urandom);
            qa.push_back(int'(ra));
            qb.push_back(int'(rb));
        end
        run_job(1'b1, 0);

        // abandon a half-loaded array, then reload from address 0
        fill_const(9, 9);
        drive_pairs(1'b0, 500);
        do_reset();
        fill_const(1, 1);
        run_job(1'b1, 0);
        check_eq("first_addr_after_rst", 64'(first_addr), 64'd0);

        // dead accelerator: timeout instance
        for (int i = 0; i < T_LEN; i++) begin
            @(negedge clk);
            t_in_valid = 1'b1;
            t_in_a = ELEM_W'(i + 1);
            t_in_b = ELEM_W'(3);
            n = 0;
            while (!t_in_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        t_in_valid = 1'b0;
        n = 0;
        while (!t_out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        v = cyc;
        check_eq("to_done_reached", 64'(t_out_valid), 64'd1);
        check_eq("to_flag", 64'(t_out_timeout), 64'd1);
        check_eq("to_result", t_out_result, 64'd0);
        check_eq("to_run_cycles", 64'(v - t_start_cyc - 1), 64'(T_TIMEOUT));
        t_out_ready = 1'b1;
        @(negedge clk);
        t_out_ready = 1'b0;
        check_eq("to_valid_cleared", 64'(t_out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_prod_driver.md
# dot_prod_driver

- Host-side initiator for the synthesized dot-product accelerator (`main`).
- Accepts a stream of LEN element pairs (a[i], b[i]) on a valid/ready input.
- Loads the pairs into the accelerator's two arrays through its `controlArr` write ports, then pulses the accelerator start/reset (`r_enable`) with zeroed initial values.
- Waits for `w_enable`, and returns the 64-bit result, or a timeout flag, on a valid/ready output.

## Interface
Parameters:
- LEN, 1000, number of element pairs per job; must equal the accelerator's compiled loop bound.
- ADDR_W, 10, array address width; LEN ≤ 2^ADDR_W.
- TIMEOUT, 4096, maximum number of RUN cycles before the job is abandoned.

Ports:
- clk  in  1  clock; single clock domain, shared with the accelerator.
- r_enable  in  1  reset; synchronous, active-high.
- in_valid  in  1  element pair valid.
- in_ready  out  1  element pair accepted when high together with in_valid.
- in_a, in_b  in  27 each (signed)  element pair.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  64 (signed)  dot product; 0 on timeout.
- out_timeout  out  1  qualifies out_result; high means the job timed out.
- busy  out  1  high in every state except LOAD.
- acc_r_enable  out  1  drives the accelerator's `r_enable`.
- acc_controlArr  out  1  drives the accelerator's `controlArr`.
- acc_init_i  out  ADDR_W  constant 0.
- acc_init_acc  out  64  constant 0.
- acc_we_a, acc_we_b  out  1 each  array write enables.
- acc_addr_a, acc_addr_b  out  ADDR_W each  array addresses.
- acc_wdata_a, acc_wdata_b  out  27 each  array write data.
- acc_w_enable  in  1  accelerator done.
- acc_result  in  64 (signed)  accelerator result.
- The accelerator's `controlArrRData_*` ports are unused.

## Operation
States, in order: LOAD, WLAST, START, RUN, DONE; DONE returns to LOAD.

- **LOAD**
  - in_ready=1, acc_controlArr=1.
  - Each accepted pair is registered: next cycle acc_we_a=acc_we_b=1, both addresses = idx, wdata = the pair. Then idx increments.
  - Acceptance of pair LEN-1 moves to WLAST.
  - While in_valid=0, the write enables fall to 0 the following cycle.
- **WLAST** (one cycle)
  - in_ready=0, acc_controlArr=1.
  - The final write (address LEN-1) is driven.
- **START** (one cycle)
  - acc_controlArr=0, write enables 0, acc_r_enable=1.
  - idx and the timeout counter clear.
- **RUN**
  - acc_r_enable=0.
  - acc_w_enable is sampled starting the cycle after START; its value during START is stale and ignored.
  - acc_w_enable=1: capture acc_result, out_timeout=0, go to DONE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without acc_w_enable, go to DONE with out_result=0 and out_timeout=1.
- **DONE**
  - out_valid=1; out_result and out_timeout are held stable.
  - out_valid & out_ready: go to LOAD with idx=0.

Reset values: state=LOAD, idx=0, counter=0, out_valid=0, out_result=0, out_timeout=0, acc_we_*=0, acc_r_enable=0, acc_controlArr=1, addresses/wdata=0. Because acc_controlArr is 1, the accelerator stays under host control from reset onward.

Boundary conditions:
- Reset mid-LOAD: the partial array is abandoned and rewritten from address 0.
- Reset mid-RUN: the accelerator keeps running, but its result is ignored. The next START re-initializes it.
- Reset has priority over every transition.
- in_valid held high across the LOAD→WLAST edge: no extra pair is accepted.
- acc_w_enable on the same cycle as the final timeout count: the result wins, out_timeout=0.
- Width rules:
  - Data passes through unmodified; no sign extension or truncation.
  - idx is ADDR_W bits and never wraps; the maximum index is LEN-1.

## Timing
- All outputs are registered except in_ready, which is a decode of the state.
- Pair accepted at cycle t → write strobes at t+1 → array updated at the end of t+1.
- Last pair accepted at t → WLAST at t+1, START at t+2, RUN from t+3.
- acc_w_enable first seen high at cycle r → out_valid at r+1.
- Minimum per-job overhead beyond LEN accept cycles: 3 cycles plus the accelerator latency.
- Sustained input rate: one pair per cycle in LOAD.

## Structure
- Package `dot_prod_pkg`:
  - constants ELEM_W=27, RES_W=64, ADDR_W=10, LEN_DEFAULT=1000;
  - state enum {LOAD, WLAST, START, RUN, DONE}.
- The accelerator shares this package's widths.
- No sub-module: the index counter and the timeout counter are inline.
- The testbench instantiates `dot_prod_driver` together with the accelerator.

## Test plan
- All a=1, b=1 → out_result=1000, out_timeout=0.
- a[i]=i, b[i]=1 → out_result=499500.
- All a=-67108864, b=67108863 → out_result=-4503599560261632000; no overflow.
- After a job, out_ready held low for 10 cycles → out_valid, out_result and out_timeout stay constant. Accept, then a second job (all a=2, b=3) → 6000.
- Stub accelerator with acc_w_enable tied 0, TIMEOUT=64 → out_valid with out_timeout=1 and out_result=0, exactly 64 RUN cycles after START.
- r_enable pulsed after 500 pairs, then a full 1000-pair all-ones job → first write of the new job is to address 0; out_result=1000.
